// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic codes,
// opcode/funct values as decoded by controlUnit, FSM states and word builders.
package enc_pkg;

   // Symbolic mnemonic codes carried on in_op; codes 25-31 are illegal.
   typedef enum logic [4:0] {
      M_NOP  = 5'd0,
      M_ADD  = 5'd1,
      M_SUB  = 5'd2,
      M_AND  = 5'd3,
      M_OR   = 5'd4,
      M_SLT  = 5'd5,
      M_XOR  = 5'd6,
      M_NOR  = 5'd7,
      M_SLL  = 5'd8,
      M_SRL  = 5'd9,
      M_JR   = 5'd10,
      M_ADDI = 5'd11,
      M_ANDI = 5'd12,
      M_ORI  = 5'd13,
      M_XORI = 5'd14,
      M_SLTI = 5'd15,
      M_LW   = 5'd16,
      M_SW   = 5'd17,
      M_BEQ  = 5'd18,
      M_BNE  = 5'd19,
      M_J    = 5'd20,
      M_JAL  = 5'd21,
      M_SGT  = 5'd22,
      M_BLTZ = 5'd23,
      M_BGEZ = 5'd24
   } mnem_t;

   // Primary opcodes (bits 31:26).
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (bits 5:0).
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // S_SECOND means word 2 of a pseudo-branch is waiting in the holding register.
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SECOND = 1'b1
   } state_t;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction input stream and machine-word output stream.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload until that edge; the
// consumer may change ready freely; the source keeps its payload stable while
// valid && !ready, and ready never depends on valid of the same channel.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;

   // Environment side: produces instructions, consumes words.
   modport master (
      output in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr, out_last
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr, out_last
   );
endinterface

// File: rtl/instr_encoder_word_fmt.sv
// Combinational formatter: maps one mnemonic plus operand fields to one or two
// machine words. Pseudo-branches use at_reg as the slt scratch destination.
module enc_word_fmt
   import enc_pkg::*;
#(
   parameter logic [4:0] AT_REG = 5'd1
) (
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word1,
   output logic [31:0] word2,
   output logic        two_word,
   output logic        illegal
);

   // Decode the mnemonic and assemble the word(s), forcing unused fields to zero.
   always_comb begin
      word1    = 32'h0000_0000;
      word2    = 32'h0000_0000;
      two_word = 1'b0;
      illegal  = 1'b0;
      case (op)
         M_NOP:  word1 = 32'h0000_0000;
         M_ADD:  word1 = r_word(rs, rt, rd, 5'd0, FN_ADD);
         M_SUB:  word1 = r_word(rs, rt, rd, 5'd0, FN_SUB);
         M_AND:  word1 = r_word(rs, rt, rd, 5'd0, FN_AND);
         M_OR:   word1 = r_word(rs, rt, rd, 5'd0, FN_OR);
         M_SLT:  word1 = r_word(rs, rt, rd, 5'd0, FN_SLT);
         M_XOR:  word1 = r_word(rs, rt, rd, 5'd0, FN_XOR);
         M_NOR:  word1 = r_word(rs, rt, rd, 5'd0, FN_NOR);
         M_SLL:  word1 = r_word(REG_ZERO, rt, rd, shamt, FN_SLL);
         M_SRL:  word1 = r_word(REG_ZERO, rt, rd, shamt, FN_SRL);
         M_JR:   word1 = r_word(rs, REG_ZERO, REG_ZERO, 5'd0, FN_JR);
         M_ADDI: word1 = i_word(OP_ADDI, rs, rt, imm);
         M_ANDI: word1 = i_word(OP_ANDI, rs, rt, imm);
         M_ORI:  word1 = i_word(OP_ORI, rs, rt, imm);
         M_XORI: word1 = i_word(OP_XORI, rs, rt, imm);
         M_SLTI: word1 = i_word(OP_SLTI, rs, rt, imm);
         M_LW:   word1 = i_word(OP_LW, rs, rt, imm);
         M_SW:   word1 = i_word(OP_SW, rs, rt, imm);
         M_BEQ:  word1 = i_word(OP_BEQ, rs, rt, imm);
         M_BNE:  word1 = i_word(OP_BNE, rs, rt, imm);
         M_J:    word1 = j_word(OP_J, target);
         M_JAL:  word1 = j_word(OP_JAL, target);
         // sgt rd,rs,rt is slt rd,rt,rs with the sources swapped.
         M_SGT:  word1 = r_word(rt, rs, rd, 5'd0, FN_SLT);
         // bltz: at = (rs < 0); branch if at != 0.
         M_BLTZ: begin
            word1    = r_word(rs, REG_ZERO, AT_REG, 5'd0, FN_SLT);
            word2    = i_word(OP_BNE, AT_REG, REG_ZERO, imm);
            two_word = 1'b1;
         end
         // bgez: at = (rs < 0); branch if at == 0.
         M_BGEZ: begin
            word1    = r_word(rs, REG_ZERO, AT_REG, 5'd0, FN_SLT);
            word2    = i_word(OP_BEQ, AT_REG, REG_ZERO, imm);
            two_word = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: accepts one symbolic instruction per
// handshake and emits registered 32-bit machine words, expanding BLTZ/BGEZ
// into two words through a one-deep holding register.
module instr_encoder
   import enc_pkg::*;
#(
   parameter logic [4:0] AT_REG = 5'd1
) (
   input  logic             clk,
   input  logic             rst,
   instr_encoder_if.slave   bus,
   output logic             err_illegal,
   output state_t           dbg_state
);

   state_t      state, state_n;
   logic        out_valid_q, out_valid_n;
   logic [31:0] out_instr_q, out_instr_n;
   logic        out_last_q, out_last_n;
   logic [31:0] word2_q, word2_n;
   logic        err_q, err_n;

   logic [31:0] fmt_word1, fmt_word2;
   logic        fmt_two_word, fmt_illegal;
   logic        in_ready, accept;

   enc_word_fmt #(.AT_REG(AT_REG)) u_fmt (
      .op       (bus.in_op),
      .rs       (bus.in_rs),
      .rt       (bus.in_rt),
      .rd       (bus.in_rd),
      .shamt    (bus.in_shamt),
      .imm      (bus.in_imm),
      .target   (bus.in_target),
      .word1    (fmt_word1),
      .word2    (fmt_word2),
      .two_word (fmt_two_word),
      .illegal  (fmt_illegal)
   );

   // Accept only when idle and the output slot is empty or draining this cycle.
   assign in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // Next-state and next-output logic for the output slot and holding register.
   always_comb begin
      state_n     = state;
      out_valid_n = out_valid_q;
      out_instr_n = out_instr_q;
      out_last_n  = out_last_q;
      word2_n     = word2_q;
      err_n       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.out_ready) begin
               out_valid_n = 1'b0;
            end
            if (accept) begin
               if (fmt_illegal) begin
                  err_n = 1'b1;
               end else begin
                  out_valid_n = 1'b1;
                  out_instr_n = fmt_word1;
                  out_last_n  = !fmt_two_word;
                  if (fmt_two_word) begin
                     word2_n = fmt_word2;
                     state_n = S_SECOND;
                  end
               end
            end
         end
         S_SECOND: begin
            // Word 1 is always valid here; replace it with word 2 once taken.
            if (bus.out_ready) begin
               out_valid_n = 1'b1;
               out_instr_n = word2_q;
               out_last_n  = 1'b1;
               state_n     = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Output slot, second-word holding register and error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0000_0000;
         out_last_q  <= 1'b0;
         word2_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_n;
         out_instr_q <= out_instr_n;
         out_last_q  <= out_last_n;
         word2_q     <= word2_n;
         err_q       <= err_n;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_last  = out_last_q;
   assign err_illegal   = err_q;
   assign dbg_state     = state;

endmodule
